// File: rtl/secuenciador_dispensado.sv
// secuenciador_dispensado: dispense-cycle FSM stepping agua..listo with a seconds prescaler; optional drink counter under CONTADOR_BEBIDAS_EN
module secuenciador_dispensado #(
  parameter int CICLOS_POR_SEG = 50000000,
  parameter int ANCHO_PRESC = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inicio,
  input  logic       cancelar,
  input  logic [1:0] bebida,
  input  logic [1:0] segundos,
  output logic [3:0] estadoActual,
  output logic [1:0] bebida_sel,
  output logic [4:0] valvulas,
  output logic       ocupado,
  output logic       listo,
  output logic       terminado,
  output logic       cancelado
`ifdef CONTADOR_BEBIDAS_EN
  ,
  output logic [7:0] contador_bebidas
`endif
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, AGUA = 4'd8, CAFE = 4'd9, LECHE = 4'd10,
    CHOCOLATE = 4'd11, AZUCAR = 4'd12, LISTO = 4'd13
  } state_t;
  state_t state_q, paso_d;
  logic carga_q;
  logic [1:0] bebida_q, seg_q;
  logic [4:0] valv_q, valv_paso;
  logic ocupado_q, listo_q, terminado_q, cancelado_q;
  logic [ANCHO_PRESC-1:0] presc_q;
  logic [3:0] idx;
  logic tick;
`ifdef CONTADOR_BEBIDAS_EN
  logic [7:0] cont_q;
  assign contador_bebidas = cont_q;
`endif
  assign idx = state_q - AGUA;
  assign tick = presc_q == ANCHO_PRESC'(CICLOS_POR_SEG - 1);
  // following step and the valve bit owned by the current step (shifts out to zero for listo/IDLE)
  always_comb begin
    paso_d = (state_q == LISTO) ? IDLE : state_t'(state_q + 4'd1);
    valv_paso = 5'd1 << idx;
  end
  // whole sequencer: start, load/count phases, cancel priority, terminal pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      carga_q <= 1'b0;
      bebida_q <= 2'd0;
      seg_q <= 2'd0;
      presc_q <= '0;
      valv_q <= 5'd0;
      ocupado_q <= 1'b0;
      listo_q <= 1'b0;
      terminado_q <= 1'b0;
      cancelado_q <= 1'b0;
`ifdef CONTADOR_BEBIDAS_EN
      cont_q <= 8'd0;
`endif
    end else begin
      terminado_q <= 1'b0;
      cancelado_q <= 1'b0;
      if (state_q == IDLE) begin
        if (inicio && !cancelar) begin
          bebida_q <= bebida;
          state_q <= AGUA;
          carga_q <= 1'b1;
          ocupado_q <= 1'b1;
        end
      end else if (cancelar) begin
        state_q <= IDLE;
        carga_q <= 1'b0;
        seg_q <= 2'd0;
        presc_q <= '0;
        valv_q <= 5'd0;
        listo_q <= 1'b0;
        ocupado_q <= 1'b0;
        cancelado_q <= 1'b1;
      end else if (carga_q && segundos != 2'd0) begin
        seg_q <= segundos;
        presc_q <= '0;
        carga_q <= 1'b0;
        valv_q <= valv_paso;
        listo_q <= state_q == LISTO;
      end else if (carga_q || (tick && seg_q == 2'd1)) begin
        state_q <= paso_d;
        carga_q <= paso_d != IDLE;
        seg_q <= 2'd0;
        presc_q <= '0;
        valv_q <= 5'd0;
        listo_q <= 1'b0;
        ocupado_q <= paso_d != IDLE;
        terminado_q <= paso_d == IDLE;
`ifdef CONTADOR_BEBIDAS_EN
        cont_q <= (paso_d == IDLE) ? cont_q + 8'd1 : cont_q;
`endif
      end else if (tick) begin
        presc_q <= '0;
        seg_q <= seg_q - 2'd1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end
  assign estadoActual = state_q;
  assign bebida_sel = bebida_q;
  assign valvulas = valv_q;
  assign ocupado = ocupado_q;
  assign listo = listo_q;
  assign terminado = terminado_q;
  assign cancelado = cancelado_q;
endmodule

// File: tb/tb_secuenciador_dispensado.sv
// tb_secuenciador_dispensado: directed checks of the dispense sequencer with a modelled time calculator
module tb_secuenciador_dispensado;
  logic clk = 1'b0, rst = 1'b1, inicio = 1'b0, cancelar = 1'b0;
  logic [1:0] bebida = 2'd0, segundos, bebida_sel;
  logic [3:0] estadoActual;
  logic [4:0] valvulas;
  logic ocupado, listo, terminado, cancelado;
`ifdef CONTADOR_BEBIDAS_EN
  logic [7:0] contador_bebidas;
`endif
  int total = 0, bad = 0;
  int cv[5];
  int n_ocu, n_listo, n_term, n_canc, n_leche, n_hot, n_sel;
  logic found;

  secuenciador_dispensado #(.CICLOS_POR_SEG(4), .ANCHO_PRESC(2)) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .cancelar(cancelar), .bebida(bebida),
    .segundos(segundos), .estadoActual(estadoActual), .bebida_sel(bebida_sel),
    .valvulas(valvulas), .ocupado(ocupado), .listo(listo), .terminado(terminado),
    .cancelado(cancelado)
`ifdef CONTADOR_BEBIDAS_EN
    , .contador_bebidas(contador_bebidas)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] calc(input logic [3:0] e, input logic [1:0] b);
    case ({b, e})
      {2'd0, 4'd8}: calc = 2'd2;
      {2'd0, 4'd9}: calc = 2'd3;
      {2'd0, 4'd12}, {2'd1, 4'd8}, {2'd1, 4'd12}, {2'd2, 4'd8}, {2'd2, 4'd12}: calc = 2'd1;
      {2'd1, 4'd9}, {2'd1, 4'd10}, {2'd2, 4'd9}: calc = 2'd2;
      {2'd2, 4'd10}: calc = 2'd3;
      {2'd3, 4'd8}, {2'd3, 4'd9}, {2'd3, 4'd10}, {2'd3, 4'd12}: calc = 2'd1;
      {2'd3, 4'd11}: calc = 2'd2;
      default: calc = (e == 4'd13) ? 2'd2 : 2'd0;
    endcase
  endfunction

  assign segundos = calc(estadoActual, bebida_sel);

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_drink(input logic [1:0] b);
    bebida = b;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    foreach (cv[k]) cv[k] = 0;
    n_ocu = 0; n_listo = 0; n_term = 0; n_canc = 0; n_leche = 0; n_hot = 0; n_sel = 0;
    for (int i = 0; i < 45; i++) begin
      for (int k = 0; k < 5; k++) if (valvulas[k]) cv[k]++;
      if (ocupado) n_ocu++;
      if (listo) n_listo++;
      if (terminado) n_term++;
      if (cancelado) n_canc++;
      if (estadoActual == 4'd10) n_leche++;
      if ($countones(valvulas) > 1 || (listo && valvulas != 5'd0)) n_hot++;
      if (ocupado && bebida_sel != b) n_sel++;
      inicio = (i == 10);
      bebida = (i >= 10) ? ~b : b;
      @(negedge clk);
    end
    inicio = 1'b0;
    bebida = b;
  endtask

  task automatic wait_for(input logic [3:0] e, input logic [4:0] v);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (estadoActual == e && valvulas == v) found = 1'b1;
      else @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_estado", estadoActual, 0);
    chk("rst_valv", valvulas, 0);
    chk("rst_flags", {ocupado, listo, terminado, cancelado}, 0);
    chk("rst_sel", bebida_sel, 0);
    rst = 1'b0;
    @(negedge clk);

    run_drink(2'd0);
    chk("exp_agua", cv[0], 8);
    chk("exp_cafe", cv[1], 12);
    chk("exp_leche", cv[2], 0);
    chk("exp_choc", cv[3], 0);
    chk("exp_azucar", cv[4], 4);
    chk("exp_listo", n_listo, 8);
    chk("exp_ocupado", n_ocu, 38);
    chk("exp_term", n_term, 1);
    chk("exp_canc", n_canc, 0);
    chk("exp_leche_visit", n_leche, 1);
    chk("exp_onehot", n_hot, 0);
    chk("exp_sel_hold", n_sel, 0);
    chk("exp_idle", estadoActual, 0);

    run_drink(2'd3);
    chk("moc_agua", cv[0], 4);
    chk("moc_cafe", cv[1], 4);
    chk("moc_leche", cv[2], 4);
    chk("moc_choc", cv[3], 8);
    chk("moc_azucar", cv[4], 4);
    chk("moc_listo", n_listo, 8);
    chk("moc_ocupado", n_ocu, 38);
    chk("moc_term", n_term, 1);
    chk("moc_onehot", n_hot, 0);
    chk("moc_sel_hold", n_sel, 0);

    bebida = 2'd2;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    chk("cap_sel", bebida_sel, 2);
    wait_for(4'd9, 5'b00010);
    chk("cap_cafe_seen", found, 1);
    cancelar = 1'b1;
    @(negedge clk);
    cancelar = 1'b0;
    chk("can_estado", estadoActual, 0);
    chk("can_valv", valvulas, 0);
    chk("can_pulse", cancelado, 1);
    chk("can_term", terminado, 0);
    chk("can_ocu", ocupado, 0);
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    chk("can_pulse_end", cancelado, 0);
    chk("restart_agua", estadoActual, 8);
    chk("restart_load", valvulas, 0);
    @(negedge clk);
    chk("restart_valv", valvulas, 1);

    wait_for(4'd10, 5'b00100);
    chk("leche_seen", found, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_estado", estadoActual, 0);
    chk("mid_rst_valv", valvulas, 0);
    chk("mid_rst_flags", {ocupado, listo, terminado, cancelado}, 0);
    chk("mid_rst_sel", bebida_sel, 0);

    inicio = 1'b1;
    cancelar = 1'b1;
    bebida = 2'd1;
    @(negedge clk);
    inicio = 1'b0;
    cancelar = 1'b0;
    chk("both_idle", estadoActual, 0);
    chk("both_ocu", ocupado, 0);
    chk("both_sel", bebida_sel, 0);
    @(negedge clk);
    chk("both_idle2", estadoActual, 0);

`ifdef CONTADOR_BEBIDAS_EN
    chk("cnt_start", contador_bebidas, 0);
    bebida = 2'd0;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    cancelar = 1'b1;
    @(negedge clk);
    cancelar = 1'b0;
    chk("cnt_cancel", contador_bebidas, 0);
    run_drink(2'd0);
    chk("cnt_one", contador_bebidas, 1);
    for (int d = 1; d < 256; d++) run_drink(2'd0);
    chk("cnt_wrap", contador_bebidas, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
